// File: rtl/rf_pkg.sv
// Shared register-file types and sizes for the writeback scoreboard slice.
package rf_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NREG      = 32;
  localparam int XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  localparam reg_idx_t X0 = '0;

  function automatic logic is_x0(reg_idx_t r);
    return r == X0;
  endfunction
endpackage

// File: rtl/rf_busy_table.sv
// Busy-bit table of pending long-latency destinations; one-cycle set/clear, combinational hazard lookup.
// Set wins over clear on the same index; x0 is never reported busy.
module rf_busy_table #(
  parameter int NREG = rf_pkg::NREG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en_i,
  input  rf_pkg::reg_idx_t set_idx_i,
  input  logic             clr_en_i,
  input  rf_pkg::reg_idx_t clr_idx_i,
  input  rf_pkg::reg_idx_t rs1_i,
  input  rf_pkg::reg_idx_t rs2_i,
  input  rf_pkg::reg_idx_t rd_i,
  output logic [NREG-1:0]  busy_o,
  output logic             hazard_o
);
  import rf_pkg::*;

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Lookups use registered state only: a result written this cycle is visible next cycle.
  assign hazard_o = (!is_x0(rs1_i) && busy_q[rs1_i]) ||
                    (!is_x0(rs2_i) && busy_q[rs2_i]) ||
                    (!is_x0(rd_i)  && busy_q[rd_i]);
  assign busy_o   = busy_q;
endmodule

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port arbiter (pipe priority, LU forced after STARVE_MAX refusals) plus LU scoreboard.
// Zero latency to the RF write port; pipe frozen via pipe_hold on a forced LU grant, LU held via lu_wb_ready.
module rf_wb_scoreboard #(
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int NREG       = rf_pkg::NREG,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_long,
  input  rf_pkg::reg_idx_t       issue_rs1,
  input  rf_pkg::reg_idx_t       issue_rs2,
  input  rf_pkg::reg_idx_t       issue_rd,
  output logic                   issue_stall,
  input  logic                   pipe_wb_valid,
  input  rf_pkg::reg_idx_t       pipe_wb_rd,
  input  logic [XLEN-1:0]        pipe_wb_data,
  output logic                   pipe_hold,
  input  logic                   lu_wb_valid,
  input  rf_pkg::reg_idx_t       lu_wb_rd,
  input  logic [XLEN-1:0]        lu_wb_data,
  output logic                   lu_wb_ready,
  output logic                   rf_we,
  output rf_pkg::reg_idx_t       rf_rd,
  output logic [XLEN-1:0]        rf_wdata,
  output logic [NREG-1:0]        busy,
  output logic                   err
);
  import rf_pkg::*;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             force_lu, lu_grant, hazard;

  assign force_lu    = (cnt_q == CNT_W'(STARVE_MAX));
  assign lu_wb_ready = !pipe_wb_valid || force_lu;
  assign pipe_hold   = pipe_wb_valid && force_lu;
  assign lu_grant    = lu_wb_valid && lu_wb_ready;
  assign issue_stall = issue_valid && hazard;

  rf_busy_table #(.NREG(NREG)) u_busy (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (issue_valid && issue_long && !issue_stall && !is_x0(issue_rd)),
    .set_idx_i (issue_rd),
    .clr_en_i  (lu_grant && !is_x0(lu_wb_rd)),
    .clr_idx_i (lu_wb_rd),
    .rs1_i     (issue_rs1),
    .rs2_i     (issue_rs2),
    .rd_i      (issue_rd),
    .busy_o    (busy),
    .hazard_o  (hazard)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = pipe_wb_rd;
    rf_wdata = pipe_wb_data;
    if (lu_grant) begin
      rf_we    = !is_x0(lu_wb_rd);
      rf_rd    = lu_wb_rd;
      rf_wdata = lu_wb_data;
    end else if (pipe_wb_valid && !pipe_hold) begin
      rf_we    = !is_x0(pipe_wb_rd);
    end
  end

  // Refusal counter never passes STARVE_MAX: at the limit the LU is always granted.
  always_comb begin
    cnt_d = '0;
    if (lu_wb_valid && !lu_wb_ready)
      cnt_d = force_lu ? cnt_q : cnt_q + 1'b1;
  end

  assign err_d = err_q || (lu_grant && !is_x0(lu_wb_rd) && !busy[lu_wb_rd]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed scenarios then random traffic, checked every cycle against a behavioural scoreboard model.
module tb_rf_wb_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_hold;
  logic        lu_wb_valid;
  logic [4:0]  lu_wb_rd;
  logic [31:0] lu_wb_data;
  logic        lu_wb_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic        err;

  rf_wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_hold(pipe_hold),
    .lu_wb_valid(lu_wb_valid), .lu_wb_rd(lu_wb_rd), .lu_wb_data(lu_wb_data),
    .lu_wb_ready(lu_wb_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  localparam int STARVE = 4;

  int errors = 0;
  int checks = 0;

  // Reference state: pending LU destinations, consecutive LU refusals, sticky error.
  bit [31:0] m_busy;
  int        m_refused;
  bit        m_err;
  bit        last_grant, last_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input logic [4:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_refused = 0; m_err = 0; last_grant = 0; last_hold = 0;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_long = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    lu_wb_valid = 0; lu_wb_rd = 0; lu_wb_data = 0;
  endtask

  // One clock: check all outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit stall_e, ready_e, hold_e, lu_g, we_e, accept;
    logic [4:0]  rd_e;
    logic [31:0] d_e;
    @(negedge clk);
    stall_e = issue_valid && (pending(issue_rs1) || pending(issue_rs2) || pending(issue_rd));
    ready_e = !pipe_wb_valid || (m_refused >= STARVE);
    hold_e  = pipe_wb_valid && (m_refused >= STARVE);
    lu_g    = lu_wb_valid && ready_e;
    we_e = 0; rd_e = 0; d_e = 0;
    if (lu_g) begin
      we_e = (lu_wb_rd != 0); rd_e = lu_wb_rd; d_e = lu_wb_data;
    end else if (pipe_wb_valid && !hold_e) begin
      we_e = (pipe_wb_rd != 0); rd_e = pipe_wb_rd; d_e = pipe_wb_data;
    end
    chk("issue_stall", issue_stall, stall_e);
    chk("lu_wb_ready", lu_wb_ready, ready_e);
    chk("pipe_hold", pipe_hold, hold_e);
    chk("rf_we", rf_we, we_e);
    if (we_e) begin
      chk("rf_rd", rf_rd, rd_e);
      chk("rf_wdata", rf_wdata, d_e);
    end
    chk("busy", busy, m_busy);
    chk("err", err, m_err);
    @(posedge clk);
    accept = issue_valid && issue_long && !stall_e && issue_rd != 0;
    if (lu_g && lu_wb_rd != 0) begin
      if (!m_busy[lu_wb_rd]) m_err = 1;
      m_busy[lu_wb_rd] = 0;
    end
    if (accept) m_busy[issue_rd] = 1;
    m_refused  = (lu_wb_valid && !ready_e) ? m_refused + 1 : 0;
    last_grant = lu_g;
    last_hold  = hold_e;
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    #3;
    chk("rst_busy", busy, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", lu_wb_ready, 1'b1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Long op to x5, dependent read stalls until the LU write, then issues.
    issue_valid = 1; issue_long = 1; issue_rd = 5;
    step();
    issue_long = 0; issue_rs1 = 5; issue_rd = 1;
    #1 chk("raw_stall", issue_stall, 1'b1);
    step();
    lu_wb_valid = 1; lu_wb_rd = 5; lu_wb_data = 32'hDEADBEEF;
    #1 chk("raw_stall_wbcyc", issue_stall, 1'b1);
    chk("lu_we", rf_we, 1'b1);
    chk("lu_rd", rf_rd, 5'd5);
    chk("lu_data", rf_wdata, 32'hDEADBEEF);
    step();
    lu_wb_valid = 0;
    #1 chk("raw_released", issue_stall, 1'b0);
    chk("busy5_clear", busy[5], 1'b0);
    step();

    // Starvation: pipe busy every cycle, LU forced through on the fifth cycle.
    issue_valid = 1; issue_long = 1; issue_rs1 = 0; issue_rd = 3;
    step();
    issue_valid = 0; issue_long = 0;
    pipe_wb_valid = 1; pipe_wb_rd = 2; pipe_wb_data = 32'h1234_5678;
    lu_wb_valid = 1; lu_wb_rd = 3; lu_wb_data = 32'hCAFE_0003;
    for (int i = 0; i < STARVE; i++) begin
      #1 chk("starve_refused", lu_wb_ready, 1'b0);
      step();
    end
    #1 chk("starve_forced", lu_wb_ready, 1'b1);
    chk("starve_hold", pipe_hold, 1'b1);
    chk("starve_rd", rf_rd, 5'd3);
    step();
    lu_wb_valid = 0;
    step();
    lu_wb_valid = 1; lu_wb_rd = 0;
    #1 chk("starve_cnt_restart", lu_wb_ready, 1'b0);
    for (int i = 0; i < STARVE + 1; i++) step();
    lu_wb_valid = 0; pipe_wb_valid = 0;

    // x0 from every source.
    issue_valid = 1; issue_long = 1; issue_rd = 0;
    #1 chk("x0_no_stall", issue_stall, 1'b0);
    step();
    chk("x0_busy", busy, 32'h0);
    issue_valid = 0; pipe_wb_valid = 1; pipe_wb_rd = 0;
    #1 chk("x0_pipe_we", rf_we, 1'b0);
    step();
    pipe_wb_valid = 0; lu_wb_valid = 1; lu_wb_rd = 0;
    #1 chk("x0_lu_ready", lu_wb_ready, 1'b1);
    chk("x0_lu_we", rf_we, 1'b0);
    step();
    lu_wb_valid = 0;

    // WAW against a pending x9.
    issue_valid = 1; issue_long = 1; issue_rd = 9;
    step();
    issue_long = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("waw_stall", issue_stall, 1'b1);
      step();
    end
    lu_wb_valid = 1; lu_wb_rd = 9; lu_wb_data = 32'h9999_0009;
    step();
    lu_wb_valid = 0;
    #1 chk("waw_released", issue_stall, 1'b0);
    step();
    issue_valid = 0;

    // Unexpected LU write sets the sticky error.
    lu_wb_valid = 1; lu_wb_rd = 7; lu_wb_data = 32'h0000_0777;
    #1 chk("err_we", rf_we, 1'b1);
    chk("err_rd", rf_rd, 5'd7);
    step();
    lu_wb_valid = 0;
    chk("err_set", err, 1'b1);
    step(); step();
    chk("err_sticky", err, 1'b1);

    // Asynchronous reset mid-operation: busy 0xA0, three refusals counted.
    issue_valid = 1; issue_long = 1; issue_rd = 5; step();
    issue_rd = 7; step();
    issue_valid = 0; issue_long = 0;
    pipe_wb_valid = 1; pipe_wb_rd = 4; lu_wb_valid = 1; lu_wb_rd = 5;
    step(); step(); step();
    chk("pre_rst_busy", busy, 32'h0000_00A0);
    #1 rst_n = 0; idle_inputs();
    #1 chk("mid_rst_busy", busy, 32'h0);
    chk("mid_rst_err", err, 1'b0);
    chk("mid_rst_ready", lu_wb_ready, 1'b1);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Random traffic under the LU hold-until-ready and pipe freeze-on-hold rules.
    for (int n = 0; n < 400; n++) begin
      if (!last_hold) begin
        pipe_wb_valid = ($urandom_range(0, 3) != 0);
        pipe_wb_rd    = 5'($urandom_range(0, 31));
        pipe_wb_data  = $urandom;
      end
      if (!lu_wb_valid || last_grant) begin
        lu_wb_valid = ($urandom_range(0, 2) == 0);
        lu_wb_data  = $urandom;
        if (m_busy != 0 && $urandom_range(0, 7) != 0) begin
          logic [4:0] r;
          do r = 5'($urandom_range(1, 31)); while (!m_busy[r]);
          lu_wb_rd = r;
        end else begin
          lu_wb_rd = 5'($urandom_range(0, 31));
        end
      end
      issue_valid = $urandom_range(0, 1);
      issue_long  = $urandom_range(0, 1);
      issue_rs1   = 5'($urandom_range(0, 7));
      issue_rs2   = 5'($urandom_range(0, 7));
      issue_rd    = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
